mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_arb_latch.sv | 35 +++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-subsystem definitions: arbiter FSM encoding, port identifiers
// and the default instruction-starvation limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_D = 1'b0,
        PORT_I = 1'b1
    } arb_port_t;

    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_arb_latch.sv
// Holds the request captured at arbitration time. It drives the downstream
// address/data, so those values persist until the next grant reloads them.
module arb_latch
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  arb_port_t         port,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output arb_port_t         lat_port,
    output logic              lat_wr,
    output logic [ADDR_W-1:0] lat_addr,
    output logic [31:0]       lat_wdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_port  <= PORT_D;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (load) begin
            lat_port  <= port;
            lat_wr    <= wr;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (data/instruction) arbiter in front of a single SRAM controller,
// with data priority bounded by an instruction-starvation counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_rd_en,
    input  logic              d_wr_en,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output arb_state_t        state
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Handshake: a requester holds rd/wr_en until its one-cycle ready pulse.
    // Downstream, mem_*_en stay high until mem_ready is seen; the completing
    // cycle is the one with mem_ready high while an enable is high.
    arb_state_t        next_state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              d_req;
    logic              grant_i;
    logic              load;
    arb_port_t         lat_port;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    assign d_req   = d_rd_en | d_wr_en;
    assign grant_i = i_rd_en && (!d_req || starve_cnt == LIMIT);
    assign load    = (state == IDLE) && (d_req || i_rd_en);

    arb_latch #(.ADDR_W(ADDR_W)) u_latch (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .port      (grant_i ? PORT_I : PORT_D),
        .wr        (grant_i ? 1'b0 : d_wr_en),
        .addr      (grant_i ? i_addr : d_addr),
        .wdata     (d_wdata),
        .lat_port  (lat_port),
        .lat_wr    (lat_wr),
        .lat_addr  (lat_addr),
        .lat_wdata (lat_wdata)
    );

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        d_ready    = 1'b0;
        i_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    next_state = grant_i ? GRANT_I : GRANT_D;
                end
            end
            GRANT_D, GRANT_I: begin
                mem_rd_en = !lat_wr;
                mem_wr_en = lat_wr;
                if (mem_ready) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                d_ready    = (lat_port == PORT_D);
                i_ready    = (lat_port == PORT_I);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counts data wins over a waiting instruction fetch; a full count hands
    // the next arbitration to the instruction port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!i_rd_en || grant_i) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata <= '0;
            i_rdata <= '0;
        end else if (mem_ready && !lat_wr) begin
            if (state == GRANT_D) begin
                d_rdata <= mem_rdata;
            end
            if (state == GRANT_I) begin
                i_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected downstream ops are queued as
// requests are driven and checked as grants appear, plus read-data/ready checks.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int OP_W   = 1 + 1 + ADDR_W + 32;

    logic              clk;
    logic              rst;
    logic              d_rd_en;
    logic              d_wr_en;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              i_rd_en;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [31:0]       i_rdata;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    arb_state_t        state;

    logic [OP_W-1:0] exp_q[$];
    logic [31:0]     exp_d_rdata;
    logic [31:0]     exp_i_rdata;
    int              n_total;
    int              n_pass;

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_rd_en   (d_rd_en),
        .d_wr_en   (d_wr_en),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .i_rd_en   (i_rd_en),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .state     (state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_op(input logic port, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata);
        exp_q.push_back({port, wr, addr, wdata});
    endtask

    // Downstream responder: waits for a grant, checks it against the oldest
    // expected op, answers after wait_cyc cycles and checks the ready pulse.
    task automatic serve(input int wait_cyc, input logic [31:0] rdata);
        logic [OP_W-1:0] op;
        logic            op_port;
        logic            op_wr;
        int              n;
        n = 0;
        while (!(mem_rd_en || mem_wr_en) && n < 20) begin
            step();
            n++;
        end
        if (!(mem_rd_en || mem_wr_en)) begin
            chk("grant_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_grant", 64'd1, 64'd0);
            return;
        end
        op      = exp_q.pop_front();
        op_port = op[OP_W-1];
        op_wr   = op[OP_W-2];
        chk("grant_port", 64'(state == GRANT_I), 64'(op_port));
        chk("grant_wr_en", 64'(mem_wr_en), 64'(op_wr));
        chk("grant_rd_en", 64'(mem_rd_en), 64'(!op_wr));
        chk("grant_addr", 64'(mem_addr), 64'(op[ADDR_W+31:32]));
        if (op_wr) chk("grant_wdata", 64'(mem_wdata), 64'(op[31:0]));
        for (int i = 0; i < wait_cyc; i++) begin
            step();
            chk("grant_hold", 64'(mem_rd_en | mem_wr_en), 64'd1);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (!op_wr) begin
            if (op_port) exp_i_rdata = rdata;
            else         exp_d_rdata = rdata;
        end
        chk("done_state", 64'(state), 64'(DONE));
        chk("done_d_ready", 64'(d_ready), 64'(!op_port));
        chk("done_i_ready", 64'(i_ready), 64'(op_port));
        chk("done_en_low", 64'(mem_rd_en | mem_wr_en), 64'd0);
        chk("done_d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
        chk("done_i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        exp_d_rdata = '0;
        exp_i_rdata = '0;
        rst         = 1'b1;
        d_rd_en     = 1'b0;
        d_wr_en     = 1'b0;
        d_addr      = '0;
        d_wdata     = '0;
        i_rd_en     = 1'b0;
        i_addr      = '0;
        mem_rdata   = '0;
        mem_ready   = 1'b0;

        // Reset state
        #1;
        chk("rst_state", 64'(state), 64'(IDLE));
        chk("rst_en", 64'({mem_rd_en, mem_wr_en, d_ready, i_ready}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rdata", 64'({d_rdata, i_rdata}), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single data read, downstream answers two cycles after the grant
        d_rd_en = 1'b1;
        d_addr  = 32'h400;
        push_op(PORT_D, 1'b0, 32'h400, 32'h0);
        step();
        chk("rd_latency", 64'(mem_rd_en), 64'd1);
        serve(2, 32'hDEADBEEF);
        d_rd_en = 1'b0;
        step();
        chk("rd_single_pulse", 64'({d_ready, i_ready}), 64'd0);

        // Simultaneous write and instruction fetch: data wins first
        d_wr_en = 1'b1;
        d_addr  = 32'h80;
        d_wdata = 32'h12345678;
        i_rd_en = 1'b1;
        i_addr  = 32'h1000;
        push_op(PORT_D, 1'b1, 32'h80, 32'h12345678);
        push_op(PORT_I, 1'b0, 32'h1000, 32'h0);
        serve(0, 32'h0);
        d_wr_en = 1'b0;
        serve(1, 32'hCAFEF00D);
        i_rd_en = 1'b0;
        step();

        // Both ports held continuously: four data grants per instruction grant
        d_rd_en = 1'b1;
        d_addr  = 32'h200;
        i_rd_en = 1'b1;
        i_addr  = 32'h3000;
        for (int g = 0; g < 10; g++) begin
            if (g % 5 == 4) push_op(PORT_I, 1'b0, 32'h3000, 32'h0);
            else            push_op(PORT_D, 1'b0, 32'h200, 32'h0);
        end
        for (int g = 0; g < 10; g++) begin
            serve(0, $urandom);
        end
        d_rd_en = 1'b0;
        i_rd_en = 1'b0;
        step();

        // Request withdrawn after the grant still completes; stray mem_ready ignored
        d_rd_en = 1'b1;
        d_addr  = 32'h500;
        push_op(PORT_D, 1'b0, 32'h500, 32'h0);
        step();
        step();
        d_rd_en = 1'b0;
        serve(1, 32'h55AA33CC);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        step();
        mem_ready = 1'b0;
        chk("stray_ready_state", 64'(state), 64'(IDLE));
        chk("stray_ready_pulse", 64'({d_ready, i_ready}), 64'd0);
        chk("stray_ready_rdata", 64'(d_rdata), 64'(exp_d_rdata));
        step();

        // Back-to-back zero-wait reads: d_ready on cycles 3 and 6
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc == 1) begin
                d_rd_en = 1'b1;
                d_addr  = 32'h400;
            end
            if (cyc == 4) d_addr = 32'h404;
            if (cyc == 7) d_rd_en = 1'b0;
            chk("b2b_d_ready", 64'(d_ready), 64'(cyc == 3 || cyc == 6));
            if (cyc == 3 || cyc == 6) chk("b2b_rdata", 64'(d_rdata), 64'(exp_d_rdata));
            if (cyc == 2) chk("b2b_addr0", 64'(mem_addr), 64'h400);
            if (cyc == 5) chk("b2b_addr1", 64'(mem_addr), 64'h404);
            mem_ready = mem_rd_en;
            mem_rdata = {16'hB2B0, mem_addr[15:0]};
            if (mem_rd_en) exp_d_rdata = mem_rdata;
            step();
        end
        mem_ready = 1'b0;

        // Reset during an instruction grant abandons it
        i_rd_en = 1'b1;
        i_addr  = 32'h44;
        step();
        chk("rst_mid_grant", 64'(state), 64'(GRANT_I));
        step();
        chk("rst_mid_rd_en", 64'(mem_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_async_state", 64'(state), 64'(IDLE));
        chk("rst_async_i_ready", 64'(i_ready), 64'd0);
        i_rd_en = 1'b0;
        step();
        rst = 1'b0;
        exp_d_rdata = '0;
        exp_i_rdata = '0;
        chk("rst_clear_addr", 64'(mem_addr), 64'd0);
        chk("rst_clear_rdata", 64'({d_rdata, i_rdata}), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_no_pulse", 64'({i_ready, d_ready}), 64'd0);
            chk("rst_idle", 64'(state), 64'(IDLE));
        end

        // Requester re-issues the abandoned fetch
        i_rd_en = 1'b1;
        push_op(PORT_I, 1'b0, 32'h44, 32'h0);
        serve(0, 32'h0BADCAFE);
        i_rd_en = 1'b0;
        step();
        chk("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
